// File: rtl/seq_pkg.sv
// Shared types and default sizes for the seq_tx serial pattern transmitter.
package seq_pkg;

    localparam int SEQ_WIDTH = 8;
    localparam int SEQ_RPT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/seq_shreg.sv
// Loadable down-indexing bit selector; holds the latched pattern and drives the
// registered serial bit (cur_bit) that feeds Out1 directly.
module seq_shreg
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             advance,
    input  logic             restart,
    input  logic             clear,
    input  logic [WIDTH-1:0] pattern,
    input  logic [IDX_W-1:0] len,
    output logic             cur_bit,
    output logic             last
);

    logic [WIDTH-1:0] pat_q;
    logic [IDX_W-1:0] len_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_m1;
    logic             bit_q;

    assign idx_m1  = idx_q - 1'b1;
    assign last    = (idx_q == '0);
    assign cur_bit = bit_q;

    // clear only zeroes the output bit so the latched pattern survives a gap cycle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pat_q <= '0;
            len_q <= '0;
            idx_q <= '0;
            bit_q <= 1'b0;
        end else if (clear) begin
            bit_q <= 1'b0;
        end else if (load) begin
            pat_q <= pattern;
            len_q <= len;
            idx_q <= len;
            bit_q <= pattern[len];
        end else if (restart) begin
            idx_q <= len_q;
            bit_q <= pat_q[len_q];
        end else if (advance) begin
            idx_q <= idx_m1;
            bit_q <= pat_q[idx_m1];
        end
    end

endmodule

// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends Pattern[Len:0] MSB-first, Repeat+1 times.
// Define SEQ_TX_GAP_EN to insert one idle GAP cycle between repetitions.
//
// state | meaning
// IDLE  | waiting for Start; nothing latched in flight
// SHIFT | Out1 carries bit idx of the latched pattern
// GAP   | one blank cycle between repetitions (SEQ_TX_GAP_EN only)
// DONE  | one-cycle Done pulse, then back to IDLE
module seq_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int RPT_W = SEQ_RPT_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Start,
    input  logic                     Abort,
    input  logic [WIDTH-1:0]         Pattern,
    input  logic [$clog2(WIDTH)-1:0] Len,
    input  logic [RPT_W-1:0]         Repeat,
    output logic                     Out1,
    output logic                     Valid,
    output logic                     Busy,
    output logic                     Done
);

    localparam int IDX_W = $clog2(WIDTH);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [RPT_W-1:0] rpt_q;
    logic             rpt_load;
    logic             rpt_dec;
    logic             sr_load;
    logic             sr_advance;
    logic             sr_restart;
    logic             sr_clear;
    logic             sr_bit;
    logic             sr_last;

    seq_shreg #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_shreg (
        .CLK     (CLK),
        .RST     (RST),
        .load    (sr_load),
        .advance (sr_advance),
        .restart (sr_restart),
        .clear   (sr_clear),
        .pattern (Pattern),
        .len     (Len),
        .cur_bit (sr_bit),
        .last    (sr_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // remaining-repetition count is tested before decrementing, so the max value never wraps
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rpt_q <= '0;
        end else if (rpt_load) begin
            rpt_q <= Repeat;
        end else if (rpt_dec) begin
            rpt_q <= rpt_q - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rpt_load   = 1'b0;
        rpt_dec    = 1'b0;
        sr_load    = 1'b0;
        sr_advance = 1'b0;
        sr_restart = 1'b0;
        sr_clear   = 1'b0;
        if (Abort) begin
            state_d  = IDLE;
            sr_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_d  = SHIFT;
                        sr_load  = 1'b1;
                        rpt_load = 1'b1;
                    end
                end
                SHIFT: begin
                    if (!sr_last) begin
                        sr_advance = 1'b1;
                    end else if (rpt_q != '0) begin
                        rpt_dec = 1'b1;
`ifdef SEQ_TX_GAP_EN
                        state_d  = GAP;
                        sr_clear = 1'b1;
`else
                        sr_restart = 1'b1;
`endif
                    end else begin
                        state_d  = DONE;
                        sr_clear = 1'b1;
                    end
                end
`ifdef SEQ_TX_GAP_EN
                GAP: begin
                    state_d    = SHIFT;
                    sr_restart = 1'b1;
                end
`endif
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign Out1  = sr_bit;
    assign Valid = (state_q == SHIFT);
    assign Busy  = (state_q == SHIFT) || (state_q == GAP);
    assign Done  = (state_q == DONE);

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: table of patterns with hand-computed bit streams,
// plus hand sequences for abort, held Start / back-to-back and mid-send reset.
module tb_seq_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Start = 1'b0;
    logic       Abort = 1'b0;
    logic [7:0] Pattern = 8'h00;
    logic [2:0] Len = 3'd0;
    logic [3:0] Repeat = 4'd0;
    logic       Out1;
    logic       Valid;
    logic       Busy;
    logic       Done;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0]  pattern;
        logic [2:0]  len;
        logic [3:0]  rpt;
        logic [31:0] exp_bits;
        logic [5:0]  nbits;
    } vec_t;

    vec_t vecs [8];

    always #5 CLK = ~CLK;

    seq_tx dut (
        .CLK     (CLK),
        .RST     (RST),
        .Start   (Start),
        .Abort   (Abort),
        .Pattern (Pattern),
        .Len     (Len),
        .Repeat  (Repeat),
        .Out1    (Out1),
        .Valid   (Valid),
        .Busy    (Busy),
        .Done    (Done)
    );

    // expected vector is {Out1, Valid, Busy, Done}
    task automatic chk(input string nm, input int id, input int cyc, input logic [3:0] exp);
        logic [3:0] got;
        got = {Out1, Valid, Busy, Done};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s id=%0d cyc=%0d got{out1,valid,busy,done}=%b exp=%b",
                     nm, id, cyc, got, exp);
        end
    endtask

    // Starts one send, scrambles the inputs after acceptance, checks every cycle through Done.
    task automatic run_vec(input vec_t v, input int id);
        int cyc;
        int k;
        @(negedge CLK);
        Pattern = v.pattern;
        Len     = v.len;
        Repeat  = v.rpt;
        Start   = 1'b1;
        cyc = 0;
        k   = 0;
        for (int r = 0; r <= int'(v.rpt); r++) begin
            for (int b = 0; b <= int'(v.len); b++) begin
                @(negedge CLK);
                cyc++;
                Start   = 1'b0;
                Pattern = ~v.pattern;
                Len     = ~v.len;
                Repeat  = ~v.rpt;
                chk("vec_bit", id, cyc, {v.exp_bits[int'(v.nbits) - 1 - k], 3'b110});
                k++;
            end
`ifdef SEQ_TX_GAP_EN
            if (r < int'(v.rpt)) begin
                @(negedge CLK);
                cyc++;
                chk("vec_gap", id, cyc, 4'b0010);
            end
`endif
        end
        @(negedge CLK);
        cyc++;
        chk("vec_done", id, cyc, 4'b0001);
    endtask

    initial begin
        logic [7:0] e1;
        logic [7:0] e2;

        vecs[0] = '{8'h02, 3'd1, 4'd0,  32'h0000_0002, 6'd2};
        vecs[1] = '{8'hA5, 3'd7, 4'd2,  32'h00A5_A5A5, 6'd24};
        vecs[2] = '{8'h5A, 3'd0, 4'd0,  32'h0000_0000, 6'd1};
        vecs[3] = '{8'h01, 3'd0, 4'd3,  32'h0000_000F, 6'd4};
        vecs[4] = '{8'h0B, 3'd3, 4'd1,  32'h0000_00BB, 6'd8};
        vecs[5] = '{8'h02, 3'd1, 4'd15, 32'hAAAA_AAAA, 6'd32};
        vecs[6] = '{8'hC3, 3'd7, 4'd0,  32'h0000_00C3, 6'd8};
        vecs[7] = '{8'h01, 3'd0, 4'd15, 32'h0000_FFFF, 6'd16};

        #12;
        chk("reset", 0, 0, 4'b0000);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("idle_after_reset", 0, 0, 4'b0000);

        // Start and Abort together in IDLE: Abort wins, nothing begins
        Pattern = 8'hFF;
        Len     = 3'd7;
        Repeat  = 4'd0;
        Start   = 1'b1;
        Abort   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            if (c == 2) begin
                Start = 1'b0;
                Abort = 1'b0;
            end
            chk("start_abort", 0, c, 4'b0000);
        end

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
            @(negedge CLK);
            chk("vec_idle", i, 0, 4'b0000);
        end

        // Abort in the 4th bit cycle
        @(negedge CLK);
        Pattern = 8'hFF;
        Len     = 3'd7;
        Repeat  = 4'd0;
        Start   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            Start = 1'b0;
            chk("abort_bits", 0, c, 4'b1110);
        end
        Abort = 1'b1;
        @(negedge CLK);
        chk("abort_next", 0, 5, 4'b0000);
        Abort = 1'b0;
        for (int c = 6; c <= 14; c++) begin
            @(negedge CLK);
            chk("abort_nodone", 0, c, 4'b0000);
        end

        // Start held through a send with Pattern changed, then back-to-back restart
        e1 = 8'h96;
        e2 = 8'h3C;
        @(negedge CLK);
        Pattern = e1;
        Len     = 3'd7;
        Repeat  = 4'd0;
        Start   = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (c == 3) Pattern = e2;
            chk("b2b_first", 0, c, {e1[8 - c], 3'b110});
        end
        @(negedge CLK);
        chk("b2b_done1", 0, 9, 4'b0001);
        @(negedge CLK);
        chk("b2b_idle", 0, 10, 4'b0000);
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            Start = 1'b0;
            chk("b2b_second", 0, c, {e2[8 - c], 3'b110});
        end
        @(negedge CLK);
        chk("b2b_done2", 0, 9, 4'b0001);
        @(negedge CLK);
        chk("b2b_idle2", 0, 10, 4'b0000);

        // Reset in the middle of a send
        e1 = 8'hA5;
        @(negedge CLK);
        Pattern = e1;
        Len     = 3'd7;
        Repeat  = 4'd2;
        Start   = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            Start = 1'b0;
            chk("rst_bits", 0, c, {e1[8 - c], 3'b110});
        end
        #1;
        RST = 1'b0;
        #1;
        chk("rst_async", 0, 0, 4'b0000);
        @(negedge CLK);
        chk("rst_held", 0, 1, 4'b0000);
        RST = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge CLK);
            chk("rst_nodone", 0, c, 4'b0000);
        end
        run_vec(vecs[0], 100);
        @(negedge CLK);
        chk("rst_recover_idle", 0, 0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
